// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: buffers byte commands in a FIFO and replays each as a framed SPI transfer.
// Optional abort input when SPI_SEQ_ABORT_EN is defined.
module spi_cmd_sequencer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_CYCLES = 18,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_slave,
    input  logic [7:0]                  cmd_data,
`ifdef SPI_SEQ_ABORT_EN
    input  logic                        abort,
`endif
    output logic                        cs1_n,
    output logic                        cs2_n,
    output logic [7:0]                  data_m,
    output logic                        busy,
    output logic                        done,
    output logic                        done_slave,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FRAME, GAP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [8:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic [LW-1:0]   w_level_nxt;
    logic            r_ready;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_data;
    logic            r_slave;
    logic            r_cs1_n;
    logic            r_cs2_n;
    logic            r_done;
    logic            r_done_slave;
    logic            r_busy;
    logic            w_abort;
    logic            w_push;
    logic            w_pop;
    logic            w_done;

`ifdef SPI_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Ready reflects only the registered full flag; a same-edge pop never frees a slot.
    assign w_push = cmd_valid && r_ready && !w_abort;

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_abort && r_level != '0) begin
                    w_pop  = 1'b1;
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_next = w_abort ? GAP : FRAME;
            end
            FRAME: begin
                if (w_abort) begin
                    w_next = GAP;
                end else if (r_cnt == CW'(FRAME_CYCLES - 1)) begin
                    w_next = GAP;
                    w_done = 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        if (w_abort) begin
            w_level_nxt = '0;
        end else begin
            w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_slave, cmd_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ready <= 1'b1;
        end else begin
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt != LW'(FIFO_DEPTH));
            if (w_abort) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_data       <= '0;
            r_slave      <= 1'b0;
            r_cs1_n      <= 1'b1;
            r_cs2_n      <= 1'b1;
            r_done       <= 1'b0;
            r_done_slave <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == FRAME || r_state == GAP) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_pop) begin
                r_data  <= r_mem[r_rptr][7:0];
                r_slave <= r_mem[r_rptr][8];
            end
            // Chip-selects follow the next state so they change on the entering edge.
            r_cs1_n <= !(w_next == FRAME && !r_slave);
            r_cs2_n <= !(w_next == FRAME && r_slave);
            r_done  <= w_done;
            if (w_done) begin
                r_done_slave <= r_slave;
            end
            r_busy <= (w_next != IDLE);
        end
    end

    assign cmd_ready  = r_ready;
    assign cs1_n      = r_cs1_n;
    assign cs2_n      = r_cs2_n;
    assign data_m     = r_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign done_slave = r_done_slave;
    assign fifo_level = r_level;

endmodule
